// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock with a registered carry,
// start/done handshake, carry/borrow and signed-overflow flags, optional unsigned saturation.
module serial_addsub #(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 2,
    parameter int SAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(N - 1);
    localparam logic             SAT_ON = (SAT_EN != 0);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opa, opb, partial;
    logic             carry, sat_q, sel_q;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] partial_nxt;
    logic             msb_cin;

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic is_sub,
                                                  input logic c,
                                                  input logic en);
        if (en && !is_sub && c)
            return '1;
        if (en && is_sub && !c)
            return '0;
        return raw;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One digit of ripple add; the new digit enters the partial result from the top.
    always_comb begin
        dsum        = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        partial_nxt = (partial >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        // Carry into this digit's top bit, recovered from the sum bit; on the last digit it is the MSB.
        msb_cin     = opa[DIGIT-1] ^ opb[DIGIT-1] ^ dsum[DIGIT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            opa     <= '0;
            opb     <= '0;
            partial <= '0;
            carry   <= 1'b0;
            sat_q   <= 1'b0;
            sel_q   <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa     <= a;
                        opb     <= b ^ {WIDTH{sel}};
                        carry   <= sel;
                        sat_q   <= sat & SAT_ON;
                        sel_q   <= sel;
                        cnt     <= '0;
                        partial <= '0;
                    end
                end
                RUN: begin
                    opa     <= opa >> DIGIT;
                    opb     <= opb >> DIGIT;
                    carry   <= dsum[DIGIT];
                    partial <= partial_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        result <= saturate(partial_nxt, sel_q, dsum[DIGIT], sat_q);
                        cout   <= dsum[DIGIT];
                        ovf    <= msb_cin ^ dsum[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
